// File: rtl/n64_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : n64_cfg_pkg
// Purpose : Shared definitions for the N64-side configuration register window:
//           register word indices, status-register bit positions and the
//           access state machine encoding.
// Ports   : (package, none)
// Options : N64_CFG_IRQ_EN (consumed by n64_cfg_regs)
// Revision: 1.0 - initial release
// ============================================================================
package n64_cfg_pkg;

   // Word index = byte address [4:2]
   typedef enum logic [2:0] {
      R_SR      = 3'd0,
      R_COMMAND = 3'd1,
      R_DATA0   = 3'd2,
      R_DATA1   = 3'd3,
      R_VERSION = 3'd4
   } reg_word_e;

   // Status register layout
   localparam int c_SR_READY_BIT   = 31;
   localparam int c_SR_BUSY_BIT    = 30;
   localparam int c_SR_ERROR_BIT   = 29;
   localparam int c_SR_IRQ_BIT     = 28;

   // Clear-request bits within an SR low-half write
   localparam int c_SR_CLR_ERR_BIT = 13;
   localparam int c_SR_CLR_IRQ_BIT = 12;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } acc_state_e;

   // Words whose low half is snapshotted by a high-half read
   function automatic logic is_shadowed(input logic [2:0] word);
      return (word == R_SR) || (word == R_DATA0) || (word == R_DATA1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/n64_halfword_asm.sv
`default_nettype none
// ============================================================================
// Module  : n64_halfword_asm
// Purpose : Bridges 16-bit half-word accesses onto 32-bit registers.
//           Writes: high half is held, low half commits the full word.
//           Reads : high half snapshots the low half so a following low read
//                   of the same word is coherent with the high half.
// Ports   : clk, reset_n      - clock, async active-low reset
//           i_soft_reset      - drops held write and read snapshot
//           i_access          - accepted access strobe (one cycle)
//           i_write           - 1=write, 0=read
//           i_word / i_low    - word index, half select (1=low half)
//           i_wdata           - write half-word
//           i_live            - current value of the addressed word
//           o_commit          - full-word write commit this cycle
//           o_commit_data     - assembled 32-bit write value
//           o_rdata           - read half-word for this access
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module n64_halfword_asm
   import n64_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_soft_reset,
   input  logic        i_access,
   input  logic        i_write,
   input  logic [2:0]  i_word,
   input  logic        i_low,
   input  logic [15:0] i_wdata,
   input  logic [31:0] i_live,
   output logic        o_commit,
   output logic [31:0] o_commit_data,
   output logic [15:0] o_rdata
);

   logic [15:0] r_hold;
   logic [2:0]  r_hold_word;
   logic        r_hold_valid;
   logic [15:0] r_shadow;
   logic [2:0]  r_shadow_word;
   logic        r_shadow_valid;

   logic w_wr;
   logic w_rd;
   logic w_hold_hit;
   logic w_shadow_hit;

   assign w_wr         = i_access &  i_write;
   assign w_rd         = i_access & ~i_write;
   assign w_hold_hit   = r_hold_valid   && (r_hold_word   == i_word);
   assign w_shadow_hit = r_shadow_valid && (r_shadow_word == i_word);

   assign o_commit      = w_wr & i_low;
   assign o_commit_data = w_hold_hit ? {r_hold, i_wdata} : {16'd0, i_wdata};
   assign o_rdata       = !i_low      ? i_live[31:16] :
                          w_shadow_hit ? r_shadow      : i_live[15:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold         <= 16'd0;
         r_hold_word    <= 3'd0;
         r_hold_valid   <= 1'b0;
         r_shadow       <= 16'd0;
         r_shadow_word  <= 3'd0;
         r_shadow_valid <= 1'b0;
      end else if (i_soft_reset) begin
         r_hold_valid   <= 1'b0;
         r_shadow_valid <= 1'b0;
      end else begin
         if (w_wr) begin
            if (!i_low) begin
               r_hold       <= i_wdata;
               r_hold_word  <= i_word;
               r_hold_valid <= 1'b1;
            end else begin
               r_hold_valid <= 1'b0;
            end
         end
         if (w_rd) begin
            if (!i_low && is_shadowed(i_word)) begin
               r_shadow       <= i_live[15:0];
               r_shadow_word  <= i_word;
               r_shadow_valid <= 1'b1;
            end else if (i_low && w_shadow_hit) begin
               // snapshot is consumed by its matching low read
               r_shadow_valid <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/n64_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module  : n64_cfg_regs
// Purpose : N64-side front end of the config/command path. Decodes PI
//           half-word accesses into a SR/COMMAND/DATA0/DATA1/VERSION window,
//           issues one-cycle command requests and reports busy/error status.
// Ports   : clk, reset_n              - clock, async active-low reset
//           n64_soft_reset            - NMI level, clears transient state
//           n64_request/write/address/wdata - PI access in
//           n64_ack, n64_rdata        - access completion, read half-word
//           cpu_ready, cpu_busy       - CPU status
//           cpu_wdata, cpu_data_write - CPU writes to DATA0/DATA1
//           cmd_request, cmd          - command pulse and latched code
//           data0, data1              - data register contents
//           irq                       - command-done interrupt
// Options : N64_CFG_IRQ_EN - enables the command-done interrupt; when not
//           defined irq and the SR irq bit are constant 0.
// Revision: 1.0 - initial release
// ============================================================================
module n64_cfg_regs
   import n64_cfg_pkg::*;
#(
   parameter logic [31:0] VERSION = 32'h5343_7632,
   parameter int          CMD_W   = 8
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             n64_soft_reset,
   input  logic             n64_request,
   input  logic             n64_write,
   input  logic [4:0]       n64_address,
   input  logic [15:0]      n64_wdata,
   output logic             n64_ack,
   output logic [15:0]      n64_rdata,
   input  logic             cpu_ready,
   input  logic             cpu_busy,
   input  logic [31:0]      cpu_wdata,
   input  logic [1:0]       cpu_data_write,
   output logic             cmd_request,
   output logic [CMD_W-1:0] cmd,
   output logic [31:0]      data0,
   output logic [31:0]      data1,
   output logic             irq
);

   acc_state_e       r_state;
   acc_state_e       w_state_nxt;
   logic             w_accept;

   logic [15:0]      r_rdata;
   logic [CMD_W-1:0] r_cmd;
   logic             r_cmd_request;
   logic             r_req_shadow;
   logic             r_cmd_error;
   logic [31:0]      r_data0;
   logic [31:0]      r_data1;

   logic [2:0]       w_word;
   logic             w_low;
   logic             w_busy;
   logic             w_irq;
   logic [31:0]      w_sr;
   logic [31:0]      w_live;
   logic             w_commit;
   logic [31:0]      w_commit_data;
   logic [15:0]      w_rd_half;
   logic             w_cmd_commit;
   logic             w_sr_commit;
   logic             w_cmd_go;
   logic             w_unused_addr0;

   assign w_word         = n64_address[4:2];
   assign w_low          = n64_address[1];
   assign w_unused_addr0 = n64_address[0];

   // r_req_shadow bridges the cycle before the CPU can raise cpu_busy
   assign w_busy = cpu_busy | r_req_shadow;

   // ------------------------------------------------------------------------
   // Access FSM: one ack cycle per accepted request; requests during ACK drop
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (n64_request) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Read view
   // ------------------------------------------------------------------------
   always_comb begin
      w_sr                 = 32'd0;
      w_sr[c_SR_READY_BIT] = cpu_ready;
      w_sr[c_SR_BUSY_BIT]  = w_busy;
      w_sr[c_SR_ERROR_BIT] = r_cmd_error;
      w_sr[c_SR_IRQ_BIT]   = w_irq;
   end

   always_comb begin
      w_live = 32'd0;
      case (w_word)
         R_SR:      w_live             = w_sr;
         R_COMMAND: w_live[CMD_W-1:0]  = r_cmd;
         R_DATA0:   w_live             = r_data0;
         R_DATA1:   w_live             = r_data1;
         R_VERSION: w_live             = VERSION;
         default:   w_live             = 32'd0;
      endcase
   end

   n64_halfword_asm u_asm (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_soft_reset  (n64_soft_reset),
      .i_access      (w_accept),
      .i_write       (n64_write),
      .i_word        (w_word),
      .i_low         (w_low),
      .i_wdata       (n64_wdata),
      .i_live        (w_live),
      .o_commit      (w_commit),
      .o_commit_data (w_commit_data),
      .o_rdata       (w_rd_half)
   );

   assign w_cmd_commit = w_commit && (w_word == R_COMMAND);
   assign w_sr_commit  = w_commit && (w_word == R_SR);
   assign w_cmd_go     = w_cmd_commit & ~w_busy;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata       <= 16'd0;
         r_cmd         <= '0;
         r_cmd_request <= 1'b0;
         r_req_shadow  <= 1'b0;
         r_cmd_error   <= 1'b0;
         r_data0       <= 32'd0;
         r_data1       <= 32'd0;
      end else begin
         // read data is only driven during the ack cycle
         r_rdata       <= (w_accept && !n64_write) ? w_rd_half : 16'd0;
         r_cmd_request <= w_cmd_go;
         r_req_shadow  <= r_cmd_request;
         if (w_cmd_go) r_cmd <= w_commit_data[CMD_W-1:0];

         if (n64_soft_reset)
            r_cmd_error <= 1'b0;
         else if (w_cmd_commit && w_busy)
            r_cmd_error <= 1'b1;
         else if (w_sr_commit && n64_wdata[c_SR_CLR_ERR_BIT])
            r_cmd_error <= 1'b0;

         // CPU write wins a same-cycle collision with an N64 commit
         if (cpu_data_write[0])
            r_data0 <= cpu_wdata;
         else if (w_commit && (w_word == R_DATA0))
            r_data0 <= w_commit_data;

         if (cpu_data_write[1])
            r_data1 <= cpu_wdata;
         else if (w_commit && (w_word == R_DATA1))
            r_data1 <= w_commit_data;
      end
   end

`ifdef N64_CFG_IRQ_EN
   logic r_irq;
   logic r_cmd_pending;
   logic r_cpu_busy_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq         <= 1'b0;
         r_cmd_pending <= 1'b0;
         r_cpu_busy_d  <= 1'b0;
      end else begin
         r_cpu_busy_d <= cpu_busy;
         if (n64_soft_reset) begin
            r_irq         <= 1'b0;
            r_cmd_pending <= 1'b0;
         end else begin
            if (r_cmd_request) r_cmd_pending <= 1'b1;
            // completion = falling edge of cpu_busy after an issued command
            if (r_cmd_pending && r_cpu_busy_d && !cpu_busy) begin
               r_irq         <= 1'b1;
               r_cmd_pending <= 1'b0;
            end else if (w_sr_commit && n64_wdata[c_SR_CLR_IRQ_BIT]) begin
               r_irq <= 1'b0;
            end
         end
      end
   end

   assign w_irq = r_irq;
`else
   assign w_irq = 1'b0;
`endif

   assign n64_ack     = (r_state == ST_ACK);
   assign n64_rdata   = r_rdata;
   assign cmd_request = r_cmd_request;
   assign cmd         = r_cmd;
   assign data0       = r_data0;
   assign data1       = r_data1;
   assign irq         = w_irq;

endmodule
`default_nettype wire

// File: tb/tb_n64_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module  : tb_n64_cfg_regs
// Purpose : Self-checking bench for n64_cfg_regs: table of PI accesses with
//           hand-computed expectations plus directed multi-cycle sequences.
// Options : N64_CFG_IRQ_EN changes the expected irq value.
// Revision: 1.0 - initial release
// ============================================================================
module tb_n64_cfg_regs;

`ifdef N64_CFG_IRQ_EN
   localparam logic c_IRQ_EXP = 1'b1;
`else
   localparam logic c_IRQ_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        n64_soft_reset;
   logic        n64_request;
   logic        n64_write;
   logic [4:0]  n64_address;
   logic [15:0] n64_wdata;
   logic        n64_ack;
   logic [15:0] n64_rdata;
   logic        cpu_ready;
   logic        cpu_busy;
   logic [31:0] cpu_wdata;
   logic [1:0]  cpu_data_write;
   logic        cmd_request;
   logic [7:0]  cmd;
   logic [31:0] data0;
   logic [31:0] data1;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   n64_cfg_regs dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .n64_soft_reset (n64_soft_reset),
      .n64_request    (n64_request),
      .n64_write      (n64_write),
      .n64_address    (n64_address),
      .n64_wdata      (n64_wdata),
      .n64_ack        (n64_ack),
      .n64_rdata      (n64_rdata),
      .cpu_ready      (cpu_ready),
      .cpu_busy       (cpu_busy),
      .cpu_wdata      (cpu_wdata),
      .cpu_data_write (cpu_data_write),
      .cmd_request    (cmd_request),
      .cmd            (cmd),
      .data0          (data0),
      .data1          (data1),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Called at a negedge; one access, returns ack-cycle read data and cmd_request
   task automatic acc(input string nm, input logic wr, input logic [4:0] a,
                      input logic [15:0] d, output logic [15:0] rd, output logic req);
      chk({nm, "_ack_pre"}, {31'd0, n64_ack}, 32'd0);
      n64_request = 1'b1;
      n64_write   = wr;
      n64_address = a;
      n64_wdata   = d;
      @(negedge clk);
      n64_request = 1'b0;
      chk({nm, "_ack"}, {31'd0, n64_ack}, 32'd1);
      rd  = n64_rdata;
      req = cmd_request;
      @(negedge clk);
      chk({nm, "_ack_end"}, {31'd0, n64_ack}, 32'd0);
      chk({nm, "_req_end"}, {31'd0, cmd_request}, 32'd0);
   endtask

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [15:0] wdata;
      logic        busy;
      logic [15:0] exp_rd;
      logic [31:0] exp_d0;
      logic [31:0] exp_d1;
      logic [7:0]  exp_cmd;
      logic        exp_req;
   } vec_t;

   vec_t vecs [19];

   logic [15:0] rd;
   logic        req;

   initial begin
      vecs[0]  = '{1'b1, 5'h08, 16'h1234, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 5'h0A, 16'h5678, 1'b0, 16'h0000, 32'h1234_5678, 32'h0000_0000, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 5'h04, 16'h0000, 1'b0, 16'h0000, 32'h1234_5678, 32'h0000_0000, 8'h00, 1'b0};
      vecs[3]  = '{1'b1, 5'h06, 16'h0042, 1'b0, 16'h0000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b1};
      vecs[4]  = '{1'b0, 5'h00, 16'h0000, 1'b0, 16'hC000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[5]  = '{1'b0, 5'h02, 16'h0000, 1'b0, 16'h0000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[6]  = '{1'b1, 5'h06, 16'h0011, 1'b1, 16'h0000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[7]  = '{1'b0, 5'h00, 16'h0000, 1'b1, 16'hE000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[8]  = '{1'b1, 5'h02, 16'h2000, 1'b1, 16'h0000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[9]  = '{1'b0, 5'h00, 16'h0000, 1'b0, 16'h8000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[10] = '{1'b0, 5'h10, 16'h0000, 1'b0, 16'h5343, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[11] = '{1'b0, 5'h12, 16'h0000, 1'b0, 16'h7632, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[12] = '{1'b0, 5'h14, 16'h0000, 1'b0, 16'h0000, 32'h1234_5678, 32'h0000_0000, 8'h42, 1'b0};
      vecs[13] = '{1'b1, 5'h0E, 16'hABCD, 1'b0, 16'h0000, 32'h1234_5678, 32'h0000_ABCD, 8'h42, 1'b0};
      vecs[14] = '{1'b1, 5'h0C, 16'h1111, 1'b0, 16'h0000, 32'h1234_5678, 32'h0000_ABCD, 8'h42, 1'b0};
      vecs[15] = '{1'b1, 5'h0A, 16'h2222, 1'b0, 16'h0000, 32'h0000_2222, 32'h0000_ABCD, 8'h42, 1'b0};
      vecs[16] = '{1'b1, 5'h0E, 16'h3333, 1'b0, 16'h0000, 32'h0000_2222, 32'h0000_3333, 8'h42, 1'b0};
      vecs[17] = '{1'b0, 5'h08, 16'h0000, 1'b0, 16'h0000, 32'h0000_2222, 32'h0000_3333, 8'h42, 1'b0};
      vecs[18] = '{1'b0, 5'h0A, 16'h0000, 1'b0, 16'h2222, 32'h0000_2222, 32'h0000_3333, 8'h42, 1'b0};

      reset_n        = 1'b0;
      n64_soft_reset = 1'b0;
      n64_request    = 1'b0;
      n64_write      = 1'b0;
      n64_address    = 5'd0;
      n64_wdata      = 16'd0;
      cpu_ready      = 1'b1;
      cpu_busy       = 1'b0;
      cpu_wdata      = 32'd0;
      cpu_data_write = 2'b00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      chk("rst_ack",   {31'd0, n64_ack},     32'd0);
      chk("rst_rdata", {16'd0, n64_rdata},   32'd0);
      chk("rst_req",   {31'd0, cmd_request}, 32'd0);
      chk("rst_cmd",   {24'd0, cmd},         32'd0);
      chk("rst_data0", data0,                32'd0);
      chk("rst_data1", data1,                32'd0);
      chk("rst_irq",   {31'd0, irq},         32'd0);

      // ---------------- table ----------------
      for (int i = 0; i < 19; i++) begin
         cpu_busy = vecs[i].busy;
         acc($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, req);
         if (!vecs[i].wr)
            chk($sformatf("v%0d_rdata", i), {16'd0, rd}, {16'd0, vecs[i].exp_rd});
         chk($sformatf("v%0d_req", i),   {31'd0, req}, {31'd0, vecs[i].exp_req});
         chk($sformatf("v%0d_data0", i), data0, vecs[i].exp_d0);
         chk($sformatf("v%0d_data1", i), data1, vecs[i].exp_d1);
         chk($sformatf("v%0d_cmd", i),   {24'd0, cmd}, {24'd0, vecs[i].exp_cmd});
      end
      cpu_busy = 1'b0;

      // ---------------- request held through the ack cycle ----------------
      n64_request = 1'b1; n64_write = 1'b0; n64_address = 5'h10;
      @(negedge clk);
      chk("hold_ack1", {31'd0, n64_ack}, 32'd1);
      @(negedge clk);
      n64_request = 1'b0;
      chk("hold_ack2", {31'd0, n64_ack}, 32'd0);
      @(negedge clk);

      // ---------------- read coherency ----------------
      acc("c_w0", 1'b1, 5'h0C, 16'hAAAA, rd, req);
      acc("c_w1", 1'b1, 5'h0E, 16'hBBBB, rd, req);
      chk("c_data1", data1, 32'hAAAA_BBBB);
      acc("c_rhi", 1'b0, 5'h0C, 16'h0, rd, req);
      chk("c_rhi_val", {16'd0, rd}, 32'h0000_AAAA);
      cpu_data_write = 2'b10; cpu_wdata = 32'hCCCC_DDDD;
      @(negedge clk);
      cpu_data_write = 2'b00;
      chk("c_cpu_data1", data1, 32'hCCCC_DDDD);
      acc("c_rlo", 1'b0, 5'h0E, 16'h0, rd, req);
      chk("c_rlo_val", {16'd0, rd}, 32'h0000_BBBB);
      // shadow of DATA0 survives an unrelated live low read of DATA1
      acc("c_rhi0", 1'b0, 5'h08, 16'h0, rd, req);
      cpu_data_write = 2'b01; cpu_wdata = 32'hFFFF_0000;
      @(negedge clk);
      cpu_data_write = 2'b00;
      acc("c_rlo1", 1'b0, 5'h0E, 16'h0, rd, req);
      chk("c_live_lo", {16'd0, rd}, 32'h0000_DDDD);
      acc("c_rlo0", 1'b0, 5'h0A, 16'h0, rd, req);
      chk("c_shadow_lo", {16'd0, rd}, 32'h0000_2222);

      // ---------------- CPU / N64 collision on DATA0 ----------------
      n64_request = 1'b1; n64_write = 1'b1; n64_address = 5'h0A; n64_wdata = 16'h0001;
      cpu_data_write = 2'b01; cpu_wdata = 32'h0000_0002;
      @(negedge clk);
      n64_request = 1'b0; cpu_data_write = 2'b00;
      chk("x_ack",   {31'd0, n64_ack}, 32'd1);
      chk("x_data0", data0, 32'h0000_0002);
      @(negedge clk);

      // ---------------- soft reset ----------------
      cpu_busy = 1'b1;
      acc("s_cmd", 1'b1, 5'h06, 16'h0099, rd, req);
      cpu_busy = 1'b0;
      acc("s_sr0", 1'b0, 5'h00, 16'h0, rd, req);
      chk("s_err_set", {16'd0, rd}, 32'h0000_A000);
      acc("s_hi", 1'b1, 5'h08, 16'h7777, rd, req);
      // soft reset coincides with a read request; the ack must still happen
      n64_soft_reset = 1'b1;
      n64_request = 1'b1; n64_write = 1'b0; n64_address = 5'h10;
      @(negedge clk);
      n64_soft_reset = 1'b0; n64_request = 1'b0;
      chk("s_ack", {31'd0, n64_ack}, 32'd1);
      chk("s_rd",  {16'd0, n64_rdata}, 32'h0000_5343);
      @(negedge clk);
      acc("s_lo", 1'b1, 5'h0A, 16'h0001, rd, req);
      chk("s_data0", data0, 32'h0000_0001);
      chk("s_data1", data1, 32'hCCCC_DDDD);
      chk("s_cmd_keep", {24'd0, cmd}, 32'h0000_0042);
      acc("s_sr1", 1'b0, 5'h00, 16'h0, rd, req);
      chk("s_err_clr", {16'd0, rd}, 32'h0000_8000);
      chk("s_irq", {31'd0, irq}, 32'd0);

      // ---------------- async reset mid-assembly ----------------
      acc("r_hi", 1'b1, 5'h08, 16'h9999, rd, req);
      reset_n = 1'b0;
      #1;
      chk("r_ack",   {31'd0, n64_ack},     32'd0);
      chk("r_rdata", {16'd0, n64_rdata},   32'd0);
      chk("r_req",   {31'd0, cmd_request}, 32'd0);
      chk("r_cmd",   {24'd0, cmd},         32'd0);
      chk("r_data0", data0,                32'd0);
      chk("r_data1", data1,                32'd0);
      chk("r_irq",   {31'd0, irq},         32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      acc("r_lo", 1'b1, 5'h0A, 16'h0055, rd, req);
      chk("r_lo_data0", data0, 32'h0000_0055);

      // ---------------- command-done interrupt ----------------
      acc("i_cmd", 1'b1, 5'h06, 16'h0007, rd, req);
      chk("i_req", {31'd0, req}, 32'd1);
      chk("i_cmd_val", {24'd0, cmd}, 32'h0000_0007);
      @(negedge clk); cpu_busy = 1'b1;
      @(negedge clk);
      @(negedge clk); cpu_busy = 1'b0;
      @(negedge clk);
      chk("i_irq_set", {31'd0, irq}, {31'd0, c_IRQ_EXP});
      acc("i_sr", 1'b0, 5'h00, 16'h0, rd, req);
      chk("i_sr_val", {16'd0, rd}, {16'd0, 1'b1, 2'b00, c_IRQ_EXP, 12'h000});
      acc("i_clr", 1'b1, 5'h02, 16'h1000, rd, req);
      chk("i_irq_clr", {31'd0, irq}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
